// File: rtl/time_counter_set.sv
`default_nettype none
// ---------------------------------------------------------------------------
// time_counter_set : stopwatch-style clock (hh:mm:ss.cc) with run/stop and
//                    field-by-field set mode.                     rev 1.0
// ---------------------------------------------------------------------------
module time_counter_set #(
  parameter int CLK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] mili,
  output logic [5:0] seg,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running,
  output logic [1:0] set_field
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    STOP     = 3'd0,
    RUN      = 3'd1,
    SET_HOUR = 3'd2,
    SET_MIN  = 3'd3,
    SET_SEG  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    mili_q, mili_d;
  logic [5:0]    seg_q, seg_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          running_q, running_d;
  logic [1:0]    set_field_q, set_field_d;

  logic ev_mode, ev_run, ev_inc;
  logic tick;

  // Only the highest-priority pulse survives; it is then applied (or ignored)
  // according to the current state.
  always_comb begin
    ev_mode = btn_mode;
    ev_run  = btn_run & ~btn_mode;
    ev_inc  = btn_inc & ~btn_mode & ~btn_run;
    tick    = (state_q == RUN) && (presc_q == PRESC_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (ev_mode)     state_d = SET_HOUR;
        else if (ev_run) state_d = RUN;
      end
      RUN: begin
        if (ev_run) state_d = STOP;
      end
      SET_HOUR: begin
        if (ev_mode) state_d = SET_MIN;
      end
      SET_MIN: begin
        if (ev_mode) state_d = SET_SEG;
      end
      SET_SEG: begin
        if (ev_mode) state_d = STOP;
      end
      default: state_d = STOP;
    endcase
  end

  // Prescaler only advances while staying in RUN; any exit or wrap zeroes it.
  always_comb begin
    presc_d = '0;
    if ((state_q == RUN) && (state_d == RUN) && !tick) presc_d = presc_q + PW'(1);
  end

  always_comb begin
    mili_d = mili_q;
    seg_d  = seg_q;
    min_d  = min_q;
    hour_d = hour_q;

    if (tick) begin
      if (mili_q == 7'd99) begin
        mili_d = 7'd0;
        if (seg_q == 6'd59) begin
          seg_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          seg_d = seg_q + 6'd1;
        end
      end else begin
        mili_d = mili_q + 7'd1;
      end
    end

    if ((state_q == STOP) && ev_mode) mili_d = 7'd0;

    if (ev_inc) begin
      case (state_q)
        SET_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        SET_MIN:  min_d  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
        SET_SEG:  seg_d  = (seg_q  == 6'd59) ? 6'd0 : seg_q  + 6'd1;
        default: ;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they land with it.
  always_comb begin
    running_d   = (state_d == RUN);
    set_field_d = 2'd0;
    case (state_d)
      SET_HOUR: set_field_d = 2'd1;
      SET_MIN:  set_field_d = 2'd2;
      SET_SEG:  set_field_d = 2'd3;
      default:  set_field_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STOP;
      presc_q     <= '0;
      mili_q      <= 7'd0;
      seg_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      running_q   <= 1'b0;
      set_field_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      mili_q      <= mili_d;
      seg_q       <= seg_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      running_q   <= running_d;
      set_field_q <= set_field_d;
    end
  end

  assign mili      = mili_q;
  assign seg       = seg_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign running   = running_q;
  assign set_field = set_field_q;

endmodule
`default_nettype wire

// File: doc/time_counter_set.md
TIME_COUNTER_SET -- requirements
Module: time_counter_set

Interface
REQ-001 Parameter: CLK_DIV, default 500000, clock cycles per centisecond tick (minimum 2).
REQ-002 Port: clk  input  1  system clock; all logic rising-edge.
REQ-003 Port: rst  input  1  synchronous reset, active-high.
REQ-004 Port: btn_run  input  1  single-cycle pulse, already debounced; toggles run/stop.
REQ-005 Port: btn_mode  input  1  single-cycle pulse, already debounced; steps through set fields.
REQ-006 Port: btn_inc  input  1  single-cycle pulse, already debounced; increments the selected field.
REQ-007 Port: mili  output  7  centiseconds, binary, range 0-99.
REQ-008 Port: seg  output  6  seconds, binary, range 0-59.
REQ-009 Port: min  output  6  minutes, binary, range 0-59.
REQ-010 Port: hour  output  5  hours, binary, range 0-23.
REQ-011 Port: running  output  1  high while in RUN.
REQ-012 Port: set_field  output  2  field being edited: 0 none, 1 hour, 2 min, 3 seg.

Function
REQ-013 The block SHALL be a single-clock design; clk is the only clock and rst is synchronous, active-high.
REQ-014 The state machine SHALL have exactly five states: STOP, RUN, SET_HOUR, SET_MIN, SET_SEG.
REQ-015 All outputs SHALL be registered and SHALL reflect an input event on the cycle after it is sampled.
REQ-016 Prescaler SHALL count 0 to CLK_DIV-1 only in RUN; tick SHALL assert on the cycle the count equals CLK_DIV-1, and the count SHALL then wrap to 0.
REQ-017 Outside RUN, the prescaler SHALL be held at 0.
REQ-018 On tick, the counters SHALL cascade as follows, all resolved in the same cycle:
- mili increments by 1;
- mili 99 SHALL wrap to 0 and carry to seg;
- seg 59 SHALL wrap to 0 and carry to min;
- min 59 SHALL wrap to 0 and carry to hour;
- hour 23 SHALL wrap to 0.
REQ-019 btn_run SHALL toggle STOP to RUN and RUN to STOP, and SHALL be ignored in the SET states.
REQ-020 btn_mode SHALL advance STOP -> SET_HOUR -> SET_MIN -> SET_SEG -> STOP, and SHALL be ignored in RUN.
REQ-021 Entering SET_HOUR SHALL clear mili to 0.
REQ-022 btn_inc in a SET state SHALL increment only the selected field, with modulo wrap (hour 23 -> 0, min or seg 59 -> 0) and no carry into other fields.
REQ-023 btn_inc SHALL be ignored in RUN and STOP.
REQ-024 When buttons assert in the same cycle, priority SHALL be btn_mode > btn_run > btn_inc; lower-priority pulses SHALL be dropped.
REQ-025 When btn_run and tick coincide in RUN, the tick increment SHALL be applied and the state SHALL become STOP.
REQ-026 running SHALL be 1 only in RUN.
REQ-027 set_field SHALL be 1, 2 or 3 in SET_HOUR, SET_MIN or SET_SEG respectively, and 0 otherwise.
REQ-028 No output SHALL ever hold a value outside its stated range.

Reset
REQ-029 While rst is high, at every clock edge:
- mili, seg, min and hour SHALL be 0;
- the prescaler SHALL be 0;
- the state SHALL be STOP, running 0, set_field 0.
REQ-030 rst SHALL override all simultaneous button pulses and ticks, including a reset asserted mid-RUN or mid-SET.

Verification (CLK_DIV=4)
REQ-031 Reset, then btn_run: running goes to 1 next cycle; mili=1 after 4 clocks, and mili=2 after 8 clocks.
REQ-032 Preload 23:59:59.99 in RUN via the set sequence, then one tick: all four fields read 0 on the following cycle.
REQ-033 From STOP: btn_mode, then 25 btn_inc pulses: set_field=1 and hour=1 (wrapped once); min, seg and mili unchanged.
REQ-034 In RUN, assert btn_mode and btn_inc: no state change and no field change; only ticks advance mili.
REQ-035 btn_run and tick in the same cycle with mili=5: mili=6 and running=0 next cycle; the prescaler then holds at 0.
REQ-036 Assert rst in SET_MIN with min=30: next cycle all fields are 0, set_field=0 and running=0.
